// File: rtl/axi_lite_master_slave.sv
// AXI4-Lite slave with a word-addressed register memory and independent write/read FSMs.
// Optional macro AXI_ADDR_CHECK_EN: out-of-range byte addresses get SLVERR instead of wrapping.
module axi_lite_master_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]      w_idx, r_idx;
    logic                  w_err, r_err;
    logic                  mem_we;
    logic                  unused_addr_bits;

    assign w_idx = AWADDR[2 +: IDX_W];
    assign r_idx = ARADDR[2 +: IDX_W];

`ifdef AXI_ADDR_CHECK_EN
    // Any set bit above the word index means the byte address is >= DEPTH*4.
    assign w_err = |AWADDR[ADDR_WIDTH-1:IDX_W+2];
    assign r_err = |ARADDR[ADDR_WIDTH-1:IDX_W+2];
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
`else
    assign w_err = 1'b0;
    assign r_err = 1'b0;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0],
                                AWADDR[ADDR_WIDTH-1:IDX_W+2], ARADDR[ADDR_WIDTH-1:IDX_W+2]};
`endif

    // The master holds address and data until the handshake edge, so they are used directly there.
    assign mem_we = (w_state_q == W_ACK) && !w_err;

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[w_idx] <= WDATA;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && WVALID) begin
                    wready_d  = 1'b1;
                    w_state_d = W_ACK;
                end
            end
            W_ACK: begin
                bvalid_d  = 1'b1;
                bresp_d   = w_err ? 2'b10 : 2'b00;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    arready_d = 1'b1;
                    r_state_d = R_ACK;
                end
            end
            R_ACK: begin
                // Sampled on the same edge as any write, so a colliding read sees the old word.
                rdata_d   = r_err ? '0 : mem[r_idx];
                rresp_d   = r_err ? 2'b10 : 2'b00;
                rvalid_d  = 1'b1;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            w_state_q <= W_IDLE;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign AWREADY = wready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_master_slave.sv
// Self-checking bench for axi_lite_master_slave: directed table, corner sequences and
// randomized traffic against a word-array reference model.
module tb_axi_lite_master_slave;
    localparam int DEPTH = 256;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 ACLK = ~ACLK;

    axi_lite_master_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit aerr(input logic [31:0] a);
`ifdef AXI_ADDR_CHECK_EN
        return a >= DEPTH * 4;
`else
        return 1'b0;
`endif
    endfunction

    // Runs a write and/or read launched together; responses held 'hold' cycles before ready.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] waddr, input logic [31:0] wdata,
                       input logic [31:0] raddr, input logic [31:0] exp_rdata,
                       input logic [1:0] exp_bresp, input logic [1:0] exp_rresp, input int hold);
        AWADDR = waddr; WDATA = wdata; ARADDR = raddr;
        AWVALID = wr; WVALID = wr; ARVALID = rd;
        BREADY = 1'b0; RREADY = 1'b0;
        tick;
        if (wr) begin
            chk("awready_pulse", AWREADY, 1);
            chk("wready_pulse", WREADY, 1);
        end
        if (rd) chk("arready_pulse", ARREADY, 1);
        tick;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("ready_drop", {AWREADY, WREADY, ARREADY}, 0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) tick;
            if (wr) begin
                chk("bvalid", BVALID, 1);
                chk("bresp", BRESP, exp_bresp);
            end
            if (rd) begin
                chk("rvalid", RVALID, 1);
                chk("rdata", RDATA, exp_rdata);
                chk("rresp", RRESP, exp_rresp);
            end
        end
        BREADY = 1'b1; RREADY = 1'b1;
        tick;
        chk("resp_done", {BVALID, RVALID}, 0);
        BREADY = 1'b0; RREADY = 1'b0;
    endtask

    // Expectations from the reference model; a read sees memory before a simultaneous write.
    task automatic model_txn(input bit wr, input bit rd, input logic [31:0] waddr,
                             input logic [31:0] wdata, input logic [31:0] raddr, input int hold);
        logic [31:0] er;
        er = aerr(raddr) ? 32'h0 : model_mem[widx(raddr)];
        txn(wr, rd, waddr, wdata, raddr, er, aerr(waddr) ? 2'b10 : 2'b00,
            aerr(raddr) ? 2'b10 : 2'b00, hold);
        if (wr && !aerr(waddr)) model_mem[widx(waddr)] = wdata;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        logic [31:0] d;

        ARESETn = 1'b1;
        AWADDR = '0; WDATA = '0; ARADDR = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        repeat (2) tick;
        chk("rst_ready", {AWREADY, WREADY, ARREADY}, 0);
        chk("rst_valid", {BVALID, RVALID}, 0);
        chk("rst_resp", {BRESP, RRESP}, 0);
        chk("rst_rdata", RDATA, 0);
        ARESETn = 1'b0;
        tick;

        vecs[0] = '{1, 0, 32'h10,  32'hCAFEBABE, 32'h0,   32'h0,        2'b00, 2'b00, 0};
        vecs[1] = '{0, 1, 32'h0,   32'h0,        32'h10,  32'hCAFEBABE, 2'b00, 2'b00, 3};
        vecs[2] = '{1, 0, 32'h0,   32'h11111111, 32'h0,   32'h0,        2'b00, 2'b00, 0};
        vecs[3] = '{1, 0, 32'h3FC, 32'h22222222, 32'h0,   32'h0,        2'b00, 2'b00, 5};
        vecs[4] = '{0, 1, 32'h0,   32'h0,        32'h0,   32'h11111111, 2'b00, 2'b00, 0};
        vecs[5] = '{0, 1, 32'h0,   32'h0,        32'h3FC, 32'h22222222, 2'b00, 2'b00, 1};
        vecs[6] = '{1, 0, 32'h13,  32'h33333333, 32'h0,   32'h0,        2'b00, 2'b00, 0};
        vecs[7] = '{0, 1, 32'h0,   32'h0,        32'h10,  32'h33333333, 2'b00, 2'b00, 0};
        foreach (vecs[i]) begin
            txn(vecs[i].wr, vecs[i].rd, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr,
                vecs[i].exp_rdata, vecs[i].exp_bresp, vecs[i].exp_rresp, vecs[i].hold);
            if (vecs[i].wr) model_mem[widx(vecs[i].waddr)] = vecs[i].wdata;
            $display("vector %0d wr=%0d rd=%0d waddr=%h raddr=%h rdata=%h", i, vecs[i].wr,
                     vecs[i].rd, vecs[i].waddr, vecs[i].raddr, RDATA);
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (i != 0 && i != 4 && i != 255) model_txn(1, 0, i * 4, $urandom, 0, 0);
        end
        $display("memory preloaded");

        // Lone AWVALID, then WVALID joins.
        AWADDR = 32'h40; WDATA = 32'h44444444; AWVALID = 1; WVALID = 0;
        repeat (4) begin
            tick;
            chk("lone_aw", {AWREADY, WREADY}, 0);
        end
        WVALID = 1;
        tick;
        chk("aw_w_accept", {AWREADY, WREADY}, 2'b11);
        tick;
        AWVALID = 0; WVALID = 0;
        chk("lone_aw_bvalid", BVALID, 1);
        BREADY = 1; tick; BREADY = 0;
        chk("lone_aw_bdone", BVALID, 0);
        model_mem[16] = 32'h44444444;
        $display("lone AWVALID sequence done");

        // Lone WVALID is never accepted and writes nothing.
        AWADDR = 32'h40; WDATA = 32'hBAD0BAD0; WVALID = 1;
        repeat (3) begin
            tick;
            chk("lone_w", {AWREADY, WREADY, BVALID}, 0);
        end
        WVALID = 0;
        model_txn(0, 1, 0, 0, 32'h40, 0);
        $display("lone WVALID sequence done");

        // A second write waits while BVALID is pending.
        AWADDR = 32'h50; WDATA = 32'h55555555; AWVALID = 1; WVALID = 1;
        tick; tick;
        AWADDR = 32'h54; WDATA = 32'h56565656;
        model_mem[20] = 32'h55555555;
        repeat (5) begin
            chk("blocked_bvalid", BVALID, 1);
            chk("blocked_ready", {AWREADY, WREADY}, 0);
            tick;
        end
        BREADY = 1;
        tick;
        BREADY = 0;
        chk("blocked_bdone", BVALID, 0);
        chk("blocked_no_accept", AWREADY, 0);
        tick;
        chk("second_accept", {AWREADY, WREADY}, 2'b11);
        tick;
        AWVALID = 0; WVALID = 0;
        chk("second_bvalid", BVALID, 1);
        BREADY = 1; tick; BREADY = 0;
        model_mem[21] = 32'h56565656;
        model_txn(0, 1, 0, 0, 32'h50, 0);
        model_txn(0, 1, 0, 0, 32'h54, 0);
        $display("BVALID backpressure sequence done");

        // Read and write to the same word on the same edge: read sees the old value.
        model_txn(1, 1, 32'h20, 32'hA5A5A5A5, 32'h20, 1);
        model_txn(0, 1, 0, 0, 32'h20, 0);
        $display("same-edge read/write done");

        // Out-of-range address: SLVERR when checked, wrap to word 0 otherwise.
        model_txn(1, 0, 32'h400, 32'hDEADBEEF, 0, 0);
        model_txn(0, 1, 0, 0, 32'h400, 0);
        model_txn(0, 1, 0, 0, 32'h0, 0);
`ifdef AXI_ADDR_CHECK_EN
        txn(0, 1, 0, 0, 32'h400, 32'h0, 2'b00, 2'b10, 0);
`endif
        $display("address range sequence done");

        // Reset during W_RESP aborts the response.
        AWADDR = 32'h60; WDATA = 32'h66666666; AWVALID = 1; WVALID = 1;
        tick; tick;
        AWVALID = 0; WVALID = 0;
        model_mem[24] = 32'h66666666;
        chk("pre_rst_bvalid", BVALID, 1);
        ARESETn = 1;
        #1;
        chk("rst_bvalid_now", BVALID, 0);
        tick;
        ARESETn = 0;
        chk("rst_idle", {AWREADY, ARREADY, RVALID}, 0);
        model_txn(1, 1, 32'h64, 32'h67676767, 32'h60, 0);
        model_txn(0, 1, 0, 0, 32'h64, 0);

        // Reset in W_ACK discards the write before memory changes.
        AWADDR = 32'h64; WDATA = 32'hBADBADBA; AWVALID = 1; WVALID = 1;
        tick;
        ARESETn = 1; AWVALID = 0; WVALID = 0;
        tick;
        ARESETn = 0;
        chk("abort_bvalid", BVALID, 0);
        model_txn(0, 1, 0, 0, 32'h64, 0);
        $display("reset abort sequences done");

        for (int i = 0; i < 60; i++) begin
            bit wr, rd;
            logic [31:0] wa, ra;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            wa = $urandom_range(0, 2047);
            ra = $urandom_range(0, 3) == 0 ? wa : 32'($urandom_range(0, 2047));
            d  = $urandom;
            model_txn(wr, rd, wa, d, ra, $urandom_range(0, 2));
            $display("random %0d wr=%0d rd=%0d waddr=%h raddr=%h rdata=%h", i, wr, rd, wa, ra, RDATA);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_master_slave.md
# axi_lite_master_slave

AXI4-Lite slave with an internal word-addressed register memory. It accepts single-beat writes and reads from an AXI-Lite master on one clock domain and returns OKAY or SLVERR responses. It serves as the memory-mapped scratch or peripheral endpoint behind the system interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of AWADDR and ARADDR.
- DATA_WIDTH, 32, data width; fixed 32-bit words.
- DEPTH, 256, number of DATA_WIDTH words in memory; must be a power of 2.

Ports (one clock; reset is asynchronous and active-high):
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous reset, active-high (asserted when 1); the name follows the bus convention.
- AWADDR  in  ADDR_WIDTH  write byte address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  DATA_WIDTH  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts the write response.
- ARADDR  in  ADDR_WIDTH  read byte address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response: OKAY or SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts the read data.

## Operation
- Word index is addr[2 +: log2(DEPTH)]. Address bits [1:0] are ignored.
- Write FSM states:
  - W_IDLE: when AWVALID & WVALID are both high, register AWREADY=WREADY=1 for exactly one cycle, then go to W_ACK. A lone AWVALID or lone WVALID is never accepted.
  - W_ACK: handshake edge. Write memory[idx] <= WDATA, set BVALID=1 and BRESP, go to W_RESP.
  - W_RESP: hold BVALID and BRESP until BREADY is sampled high. Then BVALID=0 and return to W_IDLE.
- Read FSM states (independent of the write FSM):
  - R_IDLE: when ARVALID is high, register ARREADY=1 for one cycle, go to R_ACK.
  - R_ACK: on the handshake edge, RDATA <= memory[idx], RVALID=1, RRESP set, go to R_RESP.
  - R_RESP: hold RDATA, RRESP and RVALID until RREADY is sampled high, then return to R_IDLE.
- No new write is accepted while BVALID=1. No new read is accepted while RVALID=1.
- Read and write hitting the same word on the same edge: the read returns the old data; the write completes.
- Memory contents are not reset. Only the control registers and outputs are reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, ARREADY=0, RVALID=0, RRESP=00, RDATA=0; both FSMs in IDLE.
- Assertion of ARESETn mid-transaction aborts the transaction immediately. Any write not yet performed is discarded.
- Write latency:
  - AWREADY/WREADY rise 1 cycle after the edge where both VALIDs are sampled high.
  - BVALID rises on the next edge.
- Read latency:
  - ARREADY rises 1 cycle after ARVALID is sampled.
  - RVALID and RDATA appear on the next edge.
- READY signals are single-cycle pulses. The master must hold VALID until the handshake edge.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- AXI_ADDR_CHECK_EN defined:
  - A byte address at or above DEPTH*4 gets SLVERR (2'b10).
  - Such a write leaves memory unchanged.
  - Such a read returns RDATA=0.
- AXI_ADDR_CHECK_EN undefined:
  - Upper address bits are ignored; the address wraps modulo DEPTH.
  - BRESP and RRESP are always OKAY.

## Test plan
- Write 0x10 <- 0xCAFEBABE, then read 0x10 -> RDATA=0xCAFEBABE, RRESP=00, BRESP=00.
- Write 0x0 <- 0x11111111 and 0x3FC <- 0x22222222, then read both:
  - Both values return correctly.
  - Writing 0x13 aliases to word 0x10.
- Hold BREADY low for 5 cycles after a write:
  - BVALID stays 1 and BRESP stays stable.
  - A second AWVALID/WVALID is not accepted until after BREADY.
- Assert AWVALID alone for 4 cycles, then WVALID: AWREADY/WREADY pulse only after both are high. Hold RREADY low for 3 cycles: RDATA stays stable.
- With AXI_ADDR_CHECK_EN defined, write/read 0x400 (DEPTH=256):
  - BRESP=10 and RRESP=10, RDATA=0.
  - Word 0 is unchanged.
- Assert ARESETn for 1 cycle during W_RESP: BVALID=0 immediately and both FSMs idle. A following write/read works.
